// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op codes, iteration mode type and op classification helpers
package mul_div_unit_pkg;

    localparam logic [2:0] MUL_OP   = 3'b000;
    localparam logic [2:0] MLA_OP   = 3'b001;
    localparam logic [2:0] UMULL_OP = 3'b010;
    localparam logic [2:0] SMULL_OP = 3'b011;
    localparam logic [2:0] UDIV_OP  = 3'b100;
    localparam logic [2:0] SDIV_OP  = 3'b101;

    typedef enum logic {STEP_MUL, STEP_DIV} step_mode_t;

    function automatic logic is_div(input logic [2:0] op);
        return op == UDIV_OP || op == SDIV_OP;
    endfunction

    function automatic logic is_long(input logic [2:0] op);
        return op == UMULL_OP || op == SMULL_OP;
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return op == SMULL_OP || op == SDIV_OP;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational shift-add multiply or restoring divide iteration
module mul_div_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_t         i_mode,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic [WIDTH-1:0]   i_quot,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_quot
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // multiply: conditional add into the high half then shift right; divide: shift in the next dividend bit and trial-subtract
    always_comb begin
        w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_quot[0] ? {1'b0, i_operand} : '0);
        w_sh   = {i_acc[WIDTH-1:0], i_quot[WIDTH-1]};
        w_ge   = w_sh[WIDTH] | (w_sh[WIDTH-1:0] >= i_operand);
        w_diff = w_sh[WIDTH-1:0] - i_operand;
        o_acc  = (i_mode == STEP_DIV) ? {{WIDTH{1'b0}}, (w_ge ? w_diff : w_sh[WIDTH-1:0])}
                                      : {w_sum, i_acc[WIDTH-1:1]};
        o_quot = (i_mode == STEP_DIV) ? {i_quot[WIDTH-2:0], w_ge} : {1'b0, i_quot[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with registered 64-bit result and Done pulse
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             MStart,
    input  logic [2:0]       MOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcC,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [3:0]       MFlags,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREP   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]         r_state, w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_c, r_opnd, r_q;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q, r_neg_r;
    logic               r_busy, r_done, r_dz;
    logic [WIDTH-1:0]   r_lo, r_hi;
    logic [3:0]         r_flags;

    logic               w_sgn, w_dz;
    step_mode_t         w_mode;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q_n, w_quo, w_rem;
    logic [2*WIDTH-1:0] w_acc_n, w_prod, w_res;
    logic [3:0]         w_flags;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .i_mode    (w_mode),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_quot    (r_q),
        .o_acc     (w_acc_n),
        .o_quot    (w_q_n)
    );

    // state register; reset always returns to IDLE and drops a coincident start
    always_ff @(posedge CLK) begin
        r_state <= Reset ? S_IDLE : w_next;
    end

    // next state: one PREP cycle, WIDTH RUN cycles, one FINISH cycle
    always_comb begin
        w_next = (r_state == S_IDLE) ? (MStart ? S_PREP : S_IDLE) :
                 (r_state == S_PREP) ? S_RUN :
                 (r_state == S_RUN)  ? ((r_cnt == '0) ? S_FINISH : S_RUN) : S_IDLE;
    end

    // operand magnitudes for PREP and the sign-corrected, op-selected result for FINISH
    always_comb begin
        w_sgn   = is_signed(r_op);
        w_mode  = is_div(r_op) ? STEP_DIV : STEP_MUL;
        w_abs_a = (w_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
        w_abs_b = (w_sgn && r_b[WIDTH-1]) ? -r_b : r_b;
        w_dz    = is_div(r_op) && (r_b == '0);
        w_quo   = r_neg_q ? -r_q : r_q;
        w_rem   = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_prod  = r_neg_q ? -r_acc : r_acc;
        w_res   = (r_op == MUL_OP) ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} :
                  (r_op == MLA_OP) ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0] + r_c} :
                  is_long(r_op)    ? w_prod :
                  is_div(r_op)     ? (w_dz ? {r_a, {WIDTH{1'b0}}} : {w_rem, w_quo}) : '0;
        w_flags = {(is_long(r_op) ? w_res[2*WIDTH-1] : w_res[WIDTH-1]), (w_res == '0), 2'b00};
    end

    // operand capture, sign bookkeeping and iteration datapath
    always_ff @(posedge CLK) begin
        if (r_state == S_IDLE && MStart) begin
            r_op <= MOp;
            r_a  <= SrcA;
            r_b  <= SrcB;
            r_c  <= SrcC;
        end else if (r_state == S_PREP) begin
            r_opnd  <= is_div(r_op) ? w_abs_b : w_abs_a;
            r_q     <= is_div(r_op) ? w_abs_a : w_abs_b;
            r_neg_q <= w_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_neg_r <= w_sgn & r_a[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // registered status and results; results hold until the next FINISH
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_flags <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_busy <= w_next != S_IDLE;
            r_done <= r_state == S_FINISH;
            if (r_state == S_FINISH) begin
                r_lo    <= w_res[WIDTH-1:0];
                r_hi    <= w_res[2*WIDTH-1:WIDTH];
                r_flags <= w_flags;
                r_dz    <= w_dz;
            end
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign ResultLo = r_lo;
    assign ResultHi = r_hi;
    assign MFlags   = r_flags;
    assign DivZero  = r_dz;

endmodule
